// File: rtl/iter_exec_pkg.sv
// Shared constants for the iterative execute unit: function-select codes,
// FSM state encoding and the datapath width.
package iter_exec_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] FS_MUL   = 3'b000;
   localparam logic [2:0] FS_MULHU = 3'b001;
   localparam logic [2:0] FS_SLL   = 3'b010;
   localparam logic [2:0] FS_SRL   = 3'b011;
   localparam logic [2:0] FS_SRA   = 3'b100;
   localparam logic [2:0] FS_ROR   = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   function automatic logic fs_is_mul(input logic [2:0] fs);
      return (fs == FS_MUL) || (fs == FS_MULHU);
   endfunction

   function automatic logic fs_is_legal(input logic [2:0] fs);
      return fs <= FS_ROR;
   endfunction

endpackage

// File: rtl/iter_exec_unit_if.sv
// Operand/handshake/result bundle between control unit, operand muxes,
// write-back mux and the iterative execute unit.
interface iter_exec_unit_if;
   import iter_exec_pkg::*;

   logic            START;
   logic [2:0]      FS;
   logic [XLEN-1:0] BUS_A;
   logic [XLEN-1:0] BUS_B;
   logic            BUSY;
   logic            DONE;
   logic [XLEN-1:0] F;
   logic            V;
   logic            C;
   logic            N;
   logic            Z;
   logic            ILLEGAL;

   modport master (
      output START, FS, BUS_A, BUS_B,
      input  BUSY, DONE, F, V, C, N, Z, ILLEGAL
   );

   modport slave (
      input  START, FS, BUS_A, BUS_B,
      output BUSY, DONE, F, V, C, N, Z, ILLEGAL
   );

endinterface

// File: rtl/iter_shift_step.sv
// One-bit shift/rotate of a 32-bit word selected by the function code;
// also returns the bit that falls off the word.
module iter_shift_step
   import iter_exec_pkg::*;
(
   input  logic [2:0]      fs,
   input  logic [XLEN-1:0] value,
   output logic [XLEN-1:0] next,
   output logic            out_bit
);

   always_comb begin
      next    = value;
      out_bit = 1'b0;
      case (fs)
         FS_SLL: begin
            next    = {value[XLEN-2:0], 1'b0};
            out_bit = value[XLEN-1];
         end
         FS_SRL: begin
            next    = {1'b0, value[XLEN-1:1]};
            out_bit = value[0];
         end
         FS_SRA: begin
            next    = {value[XLEN-1], value[XLEN-1:1]};
            out_bit = value[0];
         end
         FS_ROR: begin
            next    = {value[0], value[XLEN-1:1]};
            out_bit = value[0];
         end
         default: begin
            next    = value;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/iter_exec_unit.sv
// Multi-cycle execute unit: shift-add 32x32 multiply and bit-serial shifts.
// Optional ITER_EXEC_EARLY_TERM_EN ends a multiply once the multiplier is exhausted.
module iter_exec_unit
   import iter_exec_pkg::*;
#(
   parameter int CNT_W = 6
) (
   input  logic           CLK,
   input  logic           RESET,
   iter_exec_unit_if.slave bus
);

   state_t            state;
   state_t            state_nx;
   logic [2:0]        fs_r;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic [XLEN-1:0]   sh_val;
   logic [CNT_W-1:0]  cnt;

   logic [2*XLEN-1:0] acc_nx;
   logic [2*XLEN-1:0] mcand_nx;
   logic [XLEN-1:0]   mplier_nx;
   logic [XLEN-1:0]   sh_nx;
   logic              sh_out;
   logic              cnt_last;
   logic              mul_last;
   logic              mul_skip;
   logic              run_last;

   logic              load_res;
   logic [XLEN-1:0]   res_f;
   logic              res_c;
   logic              res_v;
   logic              res_ill;

   logic [XLEN-1:0]   f_r;
   logic              v_r;
   logic              c_r;
   logic              n_r;
   logic              z_r;
   logic              ill_r;

   iter_shift_step u_step (
      .fs      (fs_r),
      .value   (sh_val),
      .next    (sh_nx),
      .out_bit (sh_out)
   );

   assign acc_nx    = mplier[0] ? acc + mcand : acc;
   assign mcand_nx  = mcand << 1;
   assign mplier_nx = mplier >> 1;
   assign cnt_last  = (cnt == CNT_W'(1));

`ifdef ITER_EXEC_EARLY_TERM_EN
   // Once no multiplier bits remain, further iterations cannot change acc.
   assign mul_last = cnt_last || (mplier_nx == '0);
   assign mul_skip = (bus.BUS_B == '0);
`else
   assign mul_last = cnt_last;
   assign mul_skip = 1'b0;
`endif

   assign run_last = fs_is_mul(fs_r) ? mul_last : cnt_last;

   always_comb begin
      state_nx = state;
      load_res = 1'b0;
      res_f    = '0;
      res_c    = 1'b0;
      res_v    = 1'b0;
      res_ill  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.START) begin
               if (!fs_is_legal(bus.FS)) begin
                  state_nx = ST_FIN;
                  load_res = 1'b1;
                  res_ill  = 1'b1;
               end else if (fs_is_mul(bus.FS)) begin
                  if (mul_skip) begin
                     state_nx = ST_FIN;
                     load_res = 1'b1;
                  end else begin
                     state_nx = ST_RUN;
                  end
               end else if (bus.BUS_B[4:0] == 5'd0) begin
                  state_nx = ST_FIN;
                  load_res = 1'b1;
                  res_f    = bus.BUS_A;
               end else begin
                  state_nx = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (run_last) begin
               state_nx = ST_FIN;
               load_res = 1'b1;
               if (fs_r == FS_MUL) begin
                  res_f = acc_nx[XLEN-1:0];
                  res_c = |acc_nx[2*XLEN-1:XLEN];
                  res_v = |acc_nx[2*XLEN-1:XLEN];
               end else if (fs_r == FS_MULHU) begin
                  res_f = acc_nx[2*XLEN-1:XLEN];
               end else begin
                  res_f = sh_nx;
                  res_c = sh_out;
               end
            end
         end
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= ST_IDLE;
         fs_r   <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         sh_val <= '0;
         cnt    <= '0;
         f_r    <= '0;
         v_r    <= 1'b0;
         c_r    <= 1'b0;
         n_r    <= 1'b0;
         z_r    <= 1'b0;
         ill_r  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && bus.START) begin
            fs_r   <= bus.FS;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, bus.BUS_A};
            mplier <= bus.BUS_B;
            sh_val <= bus.BUS_A;
            cnt    <= fs_is_mul(bus.FS) ? CNT_W'(XLEN) : CNT_W'(bus.BUS_B[4:0]);
         end else if (state == ST_RUN) begin
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            sh_val <= sh_nx;
            cnt    <= cnt - CNT_W'(1);
         end
         // Result is loaded on the edge entering FIN so it is valid with DONE.
         if (load_res) begin
            f_r   <= res_f;
            v_r   <= res_v;
            c_r   <= res_c;
            n_r   <= res_f[XLEN-1];
            z_r   <= (res_f == '0);
            ill_r <= res_ill;
         end
      end
   end

   assign bus.BUSY    = (state == ST_RUN);
   assign bus.DONE    = (state == ST_FIN);
   assign bus.F       = f_r;
   assign bus.V       = v_r;
   assign bus.C       = c_r;
   assign bus.N       = n_r;
   assign bus.Z       = z_r;
   assign bus.ILLEGAL = ill_r;

endmodule
